// File: rtl/fpga_cfg_ctrl.sv
// rtl/fpga_cfg_ctrl.sv - serial bitstream loader writing logic-tile and switch-box configuration frames
// Optional per-frame even parity checking is enabled by defining CFG_PARITY_EN.
module fpga_cfg_ctrl #(
    parameter int N_TILES = 8,
    parameter int N_SBOX  = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_valid,
    input  logic               cfg_bit,
    output logic               cfg_ready,
    output logic [32:0]        frame_data,
    output logic [N_TILES-1:0] tile_we,
    output logic [N_SBOX-1:0]  sbox_we,
    output logic               fabric_en,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int N_FRAMES = N_TILES + N_SBOX;
    localparam int FW       = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
`ifdef CFG_PARITY_EN
    localparam logic [5:0] PAR_BITS = 6'd1;
`else
    localparam logic [5:0] PAR_BITS = 6'd0;
`endif
    localparam logic [FW-1:0] LAST_FRAME = FW'(N_FRAMES - 1);
    localparam logic [FW-1:0] FIRST_SBOX = FW'(N_TILES);

    typedef enum logic [2:0] {IDLE, SHIFT, WRITE, DONE, ERROR} state_t;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [5:0]    bit_cnt;
`ifdef CFG_PARITY_EN
    logic          par_acc;
`endif

    logic               in_tiles;
    logic [5:0]         frame_len;
    logic               last_bit;
    logic               payload_bit;
    logic [N_TILES-1:0] tile_sel;
    logic [N_SBOX-1:0]  sbox_sel;

    // frame_len counts the trailing parity bit when present; it never lands in frame_data
    assign in_tiles    = frame_cnt < FIRST_SBOX;
    assign frame_len   = (in_tiles ? 6'd33 : 6'd16) + PAR_BITS;
    assign last_bit    = bit_cnt == frame_len - 6'd1;
    assign payload_bit = bit_cnt < frame_len - PAR_BITS;
    assign tile_sel    = in_tiles ? (N_TILES'(1) << frame_cnt) : '0;
    assign sbox_sel    = in_tiles ? '0 : (N_SBOX'(1) << (frame_cnt - FIRST_SBOX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            bit_cnt    <= '0;
            frame_data <= '0;
            tile_we    <= '0;
            sbox_we    <= '0;
            cfg_ready  <= 1'b0;
            fabric_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef CFG_PARITY_EN
            par_acc    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state      <= SHIFT;
                        frame_cnt  <= '0;
                        bit_cnt    <= '0;
                        frame_data <= '0;
                        cfg_ready  <= 1'b1;
                        fabric_en  <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
`ifdef CFG_PARITY_EN
                        par_acc    <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (cfg_valid) begin
                        if (payload_bit) begin
                            frame_data[bit_cnt] <= cfg_bit;
                        end
                        bit_cnt <= bit_cnt + 6'd1;
`ifdef CFG_PARITY_EN
                        par_acc <= par_acc ^ cfg_bit;
`endif
                        if (last_bit) begin
                            cfg_ready <= 1'b0;
`ifdef CFG_PARITY_EN
                            if (par_acc ^ cfg_bit) begin
                                state <= ERROR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state   <= WRITE;
                                tile_we <= tile_sel;
                                sbox_we <= sbox_sel;
                            end
`else
                            state   <= WRITE;
                            tile_we <= tile_sel;
                            sbox_we <= sbox_sel;
`endif
                        end
                    end
                end
                WRITE: begin
                    tile_we    <= '0;
                    sbox_we    <= '0;
                    frame_data <= '0;
                    bit_cnt    <= '0;
`ifdef CFG_PARITY_EN
                    par_acc    <= 1'b0;
`endif
                    // frame_cnt only advances below LAST_FRAME, so it saturates there
                    if (frame_cnt == LAST_FRAME) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        fabric_en <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state     <= SHIFT;
                        cfg_ready <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpga_cfg_ctrl.sv
// tb/tb_fpga_cfg_ctrl.sv - directed table-driven bench for fpga_cfg_ctrl
module tb_fpga_cfg_ctrl;
    localparam int NT = 8;
    localparam int NS = 5;
    localparam int NF = NT + NS;
`ifdef CFG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 344 + NF * PAR;

    logic        clock = 1'b0;
    logic        reset, start, cfg_valid, cfg_bit;
    logic        cfg_ready, fabric_en, busy, done, error;
    logic [32:0] frame_data;
    logic [7:0]  tile_we;
    logic [4:0]  sbox_we;

    always #5 clock = ~clock;

    fpga_cfg_ctrl #(.N_TILES(NT), .N_SBOX(NS)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_ready(cfg_ready),
        .frame_data(frame_data), .tile_we(tile_we), .sbox_we(sbox_we),
        .fabric_en(fabric_en), .busy(busy), .done(done), .error(error)
    );

    typedef struct {
        logic [7:0]  tw;
        logic [4:0]  sw;
        logic [32:0] data;
    } vec_t;

    vec_t tab[NF];
    logic bs[NBITS];
    int   frame_end[NF];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 0);
        check({tag, "_tile_we"}, tile_we, 0);
        check({tag, "_sbox_we"}, sbox_we, 0);
        check({tag, "_frame_data"}, frame_data, 0);
        check({tag, "_fabric_en"}, fabric_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic build_stream(input int corrupt);
        int   k;
        logic p;
        k = 0;
        for (int f = 0; f < NF; f++) begin
            int len;
            len = (f < NT) ? 33 : 16;
            p = 1'b0;
            for (int b = 0; b < len; b++) begin
                bs[k] = tab[f].data[b];
                p = p ^ tab[f].data[b];
                k++;
            end
            if (PAR != 0) begin
                bs[k] = p ^ (f == corrupt);
                k++;
            end
            frame_end[f] = k;
        end
    endtask

    // Drives one load; abort_at stops at that bit count, err_after expects ERROR after that many strobes.
    task automatic run_load(input bit stall, input int start_at, input int abort_at,
                            input int err_after, output int cycles);
        int   bit_idx, ns, last_acc, last_strobe, done_cyc;
        bit   pv, pr, v, start_sent;
        bit_idx = 0; ns = 0; last_acc = -10; last_strobe = -10; done_cyc = -1;
        pv = 0; pr = 0; start_sent = 0;
        @(negedge clock);
        start = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_fabric_en", fabric_en, 0);
        check("start_cfg_ready", cfg_ready, 1);
        for (int cyc = 1; cyc < 2000; cyc++) begin
            if (pv && pr) begin
                bit_idx++;
                last_acc = cyc;
            end
            if (tile_we != 0 || sbox_we != 0) begin
                if (ns < NF) begin
                    check($sformatf("strobe%0d_tile_we", ns), tile_we, tab[ns].tw);
                    check($sformatf("strobe%0d_sbox_we", ns), sbox_we, tab[ns].sw);
                    check($sformatf("strobe%0d_data", ns), frame_data, tab[ns].data);
                    check($sformatf("strobe%0d_pos", ns), bit_idx, frame_end[ns]);
                end
                check($sformatf("strobe%0d_latency", ns), last_acc, cyc);
                check($sformatf("strobe%0d_one_cycle", ns), (cyc - last_strobe) > 1, 1);
                check($sformatf("strobe%0d_cfg_ready", ns), cfg_ready, 0);
                ns++;
                last_strobe = cyc;
            end
            if (done || error) begin
                done_cyc = cyc;
                break;
            end
            if (abort_at >= 0 && bit_idx == abort_at) break;
            start = (!start_sent && start_at >= 0 && bit_idx == start_at);
            if (start) start_sent = 1;
            v = (bit_idx < NBITS) && (!stall || (cyc % 2 == 1));
            cfg_valid = v;
            cfg_bit = v ? bs[bit_idx] : 1'b0;
            pv = v;
            pr = cfg_ready;
            @(negedge clock);
        end
        start = 1'b0;
        cfg_valid = 1'b0;
        cycles = done_cyc;
        if (err_after >= 0) begin
            check("err_strobes", ns, err_after);
            check("err_flag", error, 1);
            check("err_fabric_en", fabric_en, 0);
            check("err_busy", busy, 0);
            check("err_cfg_ready", cfg_ready, 0);
            check("err_done", done, 0);
        end else if (abort_at < 0) begin
            check("load_finished", done_cyc > 0, 1);
            check("strobe_count", ns, NF);
            check("done_latency", done_cyc - last_strobe, 1);
            check("done_flag", done, 1);
            check("done_fabric_en", fabric_en, 1);
            check("done_busy", busy, 0);
            check("done_error", error, 0);
            check("done_cfg_ready", cfg_ready, 0);
        end
    endtask

    initial begin
        int c;
        tab[0]  = '{8'h01, 5'h00, 33'h0_1234_5678};
        tab[1]  = '{8'h02, 5'h00, 33'h1_FFFF_FFFF};
        tab[2]  = '{8'h04, 5'h00, 33'h0_0000_0000};
        tab[3]  = '{8'h08, 5'h00, 33'h1_0000_8001};
        tab[4]  = '{8'h10, 5'h00, 33'h0_DEAD_BEEF};
        tab[5]  = '{8'h20, 5'h00, 33'h1_5555_AAAA};
        tab[6]  = '{8'h40, 5'h00, 33'h0_8000_0001};
        tab[7]  = '{8'h80, 5'h00, 33'h1_0F0F_F0F0};
        tab[8]  = '{8'h00, 5'h01, 33'h0_0000_0001};
        tab[9]  = '{8'h00, 5'h02, 33'h0_0000_FFFF};
        tab[10] = '{8'h00, 5'h04, 33'h0_0000_A5C3};
        tab[11] = '{8'h00, 5'h08, 33'h0_0000_8000};
        tab[12] = '{8'h00, 5'h10, 33'h0_0000_3C5A};

        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        cfg_valid = 1'b1;
        cfg_bit = 1'b1;
        repeat (3) @(negedge clock);
        check_zero("idle_valid_ignored");
        cfg_valid = 1'b0;

        build_stream(-1);
        run_load(0, -1, -1, -1, c);
        check("full_cycles", c, NBITS + NF + 1);
        repeat (4) @(negedge clock);
        check("done_hold", done, 1);
        check("fabric_en_hold", fabric_en, 1);

        run_load(1, -1, -1, -1, c);
        check("stall_cycles", c >= 2 * NBITS, 1);

        run_load(0, -1, 100, -1, c);
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        check_zero("reset_mid_frame");
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_zero("no_resume");

        run_load(0, -1, 33 + PAR, -1, c);
        check("write_strobe_before_reset", tile_we, 8'h01);
        reset = 1'b1;
        #1;
        check_zero("reset_in_write");
        @(negedge clock);
        reset = 1'b0;

        run_load(0, -1, -1, -1, c);
        check("after_reset_cycles", c, NBITS + NF + 1);

        run_load(0, 50, -1, -1, c);
        check("start_in_shift_cycles", c, NBITS + NF + 1);

`ifdef CFG_PARITY_EN
        build_stream(2);
        run_load(0, -1, -1, 2, c);
        repeat (3) @(negedge clock);
        check("err_hold", error, 1);
        build_stream(-1);
        run_load(0, -1, -1, -1, c);
        check("err_recover_cycles", c, NBITS + NF + 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpga_cfg_ctrl.md
FPGA_CFG_CTRL -- requirements
Module: fpga_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter N_TILES, default 8, number of logic-tile frames loaded per bitstream.
REQ-002 The block SHALL have parameter N_SBOX, default 5, number of switch-box frames loaded per bitstream.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle pulse that begins a configuration load.
REQ-006 The block SHALL have port cfg_valid, input, 1, serial bitstream bit valid.
REQ-007 The block SHALL have port cfg_bit, input, 1, serial bitstream bit, LSB of each frame first.
REQ-008 The block SHALL have port cfg_ready, output, 1, bit acceptance; a bit transfers when cfg_valid and cfg_ready are both high.
REQ-009 The block SHALL have port frame_data, output, 33, assembled frame; switch boxes use bits [15:0].
REQ-010 The block SHALL have port tile_we, output, N_TILES, one-hot write strobe into tile i's 33-bit LUT/FF-select memory.
REQ-011 The block SHALL have port sbox_we, output, N_SBOX, one-hot write strobe into switch box j's 16-bit configure register.
REQ-012 The block SHALL have port fabric_en, output, 1, fabric run enable; low while configuration is incomplete.
REQ-013 The block SHALL have ports busy, done and error, output, 1 bit each, status flags.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, WRITE, DONE and ERROR.
REQ-015 Frame order SHALL be tiles 0..N_TILES-1 at 33 bits each, then switch boxes 0..N_SBOX-1 at 16 bits each; the default total is 344 payload bits.
REQ-016 In IDLE, DONE or ERROR, start SHALL clear the frame and bit counters, clear done and error, drive fabric_en low and enter SHIFT on the next cycle.
REQ-017 start SHALL be ignored in SHIFT and WRITE.
REQ-018 cfg_ready SHALL be high only in SHIFT; cfg_valid outside SHIFT SHALL have no effect.
REQ-019 Each accepted bit SHALL be stored at frame_data[bit_cnt], and bit_cnt SHALL increment by one.
REQ-020 Stalls (cfg_valid low) SHALL hold all state.
REQ-021 After the last bit of a frame is accepted, the FSM SHALL enter WRITE on the next cycle.
REQ-022 In WRITE, exactly one bit of tile_we or sbox_we SHALL be high for exactly one cycle, frame_data SHALL be stable, and cfg_ready SHALL be low.
REQ-023 On leaving WRITE, frame_data SHALL be cleared to 0 and bit_cnt reset to 0.
REQ-024 On leaving WRITE, the FSM SHALL return to SHIFT, or go to DONE if the frame just written was the last switch-box frame.
REQ-025 In DONE, done and fabric_en SHALL be 1 and busy SHALL be 0; these SHALL hold until the next start.
REQ-026 busy SHALL be 1 in SHIFT and WRITE.
REQ-027 Latency from the last accepted bit to the write strobe SHALL be exactly 1 cycle.
REQ-028 Latency from the final write strobe to done SHALL be exactly 1 cycle.
REQ-029 No write strobe SHALL ever fire outside WRITE.
REQ-030 Counters SHALL never wrap; the frame counter saturates at N_TILES+N_SBOX-1.

Reset
REQ-031 Asserting reset at any time, including mid-frame or during WRITE, SHALL immediately force IDLE.
REQ-032 On reset, the outputs SHALL take these values: cfg_ready=0, tile_we=0, sbox_we=0, frame_data=0, fabric_en=0, busy=0, done=0, error=0, and both counters 0.
REQ-033 A partially loaded bitstream SHALL NOT be resumed after reset; a new start is required.

Configuration
REQ-034 The macro CFG_PARITY_EN SHALL select per-frame parity checking; undefined, there is no parity bit and there is no path to ERROR.
REQ-035 With CFG_PARITY_EN defined, each frame SHALL carry one extra trailing even-parity bit, making the total frame ones count even; this bit is not stored in frame_data.
REQ-036 With CFG_PARITY_EN defined, a parity mismatch SHALL suppress the write strobe and enter ERROR instead of WRITE.
REQ-037 In ERROR, error=1, busy=0, fabric_en=0 and cfg_ready=0 SHALL hold until start or reset.

Verification
REQ-038 Bench scenario, full load: reset, start, then 344 bits with cfg_valid always high -> 13 one-cycle strobes; tile_we=8'h01 occurs 1 cycle after bit 33; done=1 and fabric_en=1 occur 1 cycle after the sbox_we=5'h10 strobe.
REQ-039 Bench scenario, content: tile 3 frame = 33'h1_0000_8001 and sbox 2 frame = 16'hA5C3 -> frame_data equals those values during tile_we=8'h08 and sbox_we=5'h04 respectively.
REQ-040 Bench scenario, stalls: cfg_valid toggled 1,0,1,0 throughout -> identical strobes and data as the full-load scenario, with cycle count doubled; no strobe while stalled.
REQ-041 Bench scenario, reset mid-operation: assert reset after 100 bits -> all outputs 0 within the same cycle; a subsequent start and 344 bits -> correct load.
REQ-042 Bench scenario, start in SHIFT: pulse start at bit 50 -> ignored; the load completes normally.
REQ-043 Bench scenario, CFG_PARITY_EN: corrupt the parity bit of frame 2 -> only the tile_we 8'h01 and 8'h02 strobes occur, then error=1 and fabric_en=0; start recovers.
